// File: rtl/fifo_reader_pkg.sv
// Shared types and helpers for the FIFO read-side consumer.
package fifo_reader_pkg;

  // Consumer FSM states, 2-bit encoding.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    CHECK = 2'd3
  } state_t;

  // Default accept window: printable ASCII.
  localparam logic [7:0] ASCII_LO = 8'h20;
  localparam logic [7:0] ASCII_HI = 8'h7E;

  // Inclusive unsigned range test; callers zero-extend to 32 bits.
  function automatic logic in_window(input logic [31:0] q,
                                     input logic [31:0] lo,
                                     input logic [31:0] hi);
    return (q >= lo) && (q <= hi);
  endfunction

endpackage

// File: rtl/fifo_reader_acc_cnt.sv
// Accepted-byte counter. Plain binary by default; packed BCD (two digits per
// byte) when FIFO_READER_BCD_EN is defined. wrap pulses with the increment
// that rolls the counter from full scale back to zero.
module acc_cnt #(
  parameter int W = 8
) (
  input  logic         clk_sys,
  input  logic         rst_b,
  input  logic         inc,
  output logic [W-1:0] value,
  output logic         wrap
);

  logic [W-1:0] value_nx;
  logic         carry_out;

`ifdef FIFO_READER_BCD_EN
  localparam int ND = W / 4;

  // Ripple +1 through the BCD digits; carry out of the top digit is a roll-over.
  always_comb begin
    logic carry;
    value_nx = value;
    carry    = 1'b1;
    for (int d = 0; d < ND; d++) begin
      if (carry) begin
        if (value[d*4 +: 4] >= 4'd9) begin
          value_nx[d*4 +: 4] = 4'd0;
        end else begin
          value_nx[d*4 +: 4] = value[d*4 +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
    carry_out = carry;
  end
`else
  // Binary increment; roll-over happens only from all-ones.
  always_comb begin
    value_nx  = value + 1'b1;
    carry_out = &value;
  end
`endif

  assign wrap = inc & carry_out;

  // Count register, advanced only on an accepted byte.
  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      value <= '0;
    end else if (inc) begin
      value <= value_nx;
    end
  end

endmodule

// File: rtl/fifo_reader.sv
// Read side of the generator -> FIFO link. Pops one byte at a time from a
// normal (non-show-ahead) FIFO, keeps bytes inside [LO, HI] and counts them.
// Optional packed-BCD count selected by FIFO_READER_BCD_EN (see acc_cnt).
//
// state | meaning
// IDLE  | waiting for both enables and a non-empty FIFO
// REQ   | rdreq high for this single cycle
// WAIT  | extra read-latency cycles (only when RD_LAT > 1)
// CHECK | q valid: range-check, count and capture
module fifo_reader
  import fifo_reader_pkg::*;
#(
  parameter int             DW     = 8,
  parameter int             CNT_W  = 8,
  parameter logic [DW-1:0]  LO     = DW'(ASCII_LO),
  parameter logic [DW-1:0]  HI     = DW'(ASCII_HI),
  parameter int             RD_LAT = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ENraf,
  input  logic             Enwrk,
  input  logic             empty,
  input  logic [DW-1:0]    q,
  output logic             rdreq,
  output logic [CNT_W-1:0] bc,
  output logic [DW-1:0]    last,
  output logic             busy,
  output logic             ovf
);

  // WAIT lasts RD_LAT-1 cycles: load RD_LAT-2 and leave on terminal count 0.
  localparam logic [1:0] LAT_LOAD = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;

  state_t     state, state_nx;
  logic [1:0] lat_cnt;
  logic       accept;
  logic       wrap;

  // State register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state decode; enables and empty only matter in IDLE so an
  // in-flight byte always completes.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (ENraf && Enwrk && !empty) state_nx = REQ;
      REQ:     state_nx = (RD_LAT > 1) ? WAIT : CHECK;
      WAIT:    if (lat_cnt == 2'd0) state_nx = CHECK;
      CHECK:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Read-latency down-counter, loaded while the request is out.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      lat_cnt <= 2'd0;
    end else if (state == REQ) begin
      lat_cnt <= LAT_LOAD;
    end else if (state == WAIT && lat_cnt != 2'd0) begin
      lat_cnt <= lat_cnt - 2'd1;
    end
  end

  // Registered handshake outputs, decoded from the state being entered.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rdreq <= 1'b0;
      busy  <= 1'b0;
    end else begin
      rdreq <= (state_nx == REQ);
      busy  <= (state_nx != IDLE);
    end
  end

  assign accept = (state == CHECK) && in_window(32'(q), 32'(LO), 32'(HI));

  // Capture the last accepted byte and latch a counter roll-over.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      last <= '0;
      ovf  <= 1'b0;
    end else begin
      if (accept) last <= q;
      if (wrap)   ovf  <= 1'b1;
    end
  end

  acc_cnt #(
    .W (CNT_W)
  ) u_acc_cnt (
    .clk_sys (CLK),
    .rst_b   (RST),
    .inc     (accept),
    .value   (bc),
    .wrap    (wrap)
  );

endmodule

// File: tb/tb_fifo_reader.sv
// Directed bench for fifo_reader: one instance with RD_LAT=1 and one with
// RD_LAT=2, each fed by a small behavioural normal-mode FIFO.
module tb_fifo_reader;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       Enwrk = 1'b1;
  logic       enr1 = 1'b1, enr2 = 1'b0;
  logic       hold1 = 1'b0;
  logic       empty1, empty2;
  logic [7:0] q1 = 8'h00, q2 = 8'h00, p2 = 8'h00;
  logic       rdreq1, rdreq2, busy1, busy2, ovf1, ovf2;
  logic [7:0] bc1, bc2, last1, last2;

  logic [7:0] mem1 [0:511];
  logic [7:0] mem2 [0:15];
  int wr1 = 0, rd1 = 0, wr2 = 0, rd2 = 0;
  int nvec = 0, nfail = 0;

  always #5 CLK = ~CLK;

  assign empty1 = (wr1 == rd1) || hold1;
  assign empty2 = (wr2 == rd2);

  // FIFO 1: data one edge after the read request.
  always @(posedge CLK) begin
    if (rdreq1) begin
      q1  <= mem1[rd1];
      rd1 <= rd1 + 1;
    end
  end

  // FIFO 2: data two edges after the read request.
  always @(posedge CLK) begin
    if (rdreq2) begin
      p2  <= mem2[rd2];
      rd2 <= rd2 + 1;
    end
    q2 <= p2;
  end

  fifo_reader #(.DW(8), .CNT_W(8), .LO(8'h20), .HI(8'h7E), .RD_LAT(1)) u_d1 (
    .CLK(CLK), .RST(RST), .ENraf(enr1), .Enwrk(Enwrk), .empty(empty1), .q(q1),
    .rdreq(rdreq1), .bc(bc1), .last(last1), .busy(busy1), .ovf(ovf1));

  fifo_reader #(.DW(8), .CNT_W(8), .LO(8'h20), .HI(8'h7E), .RD_LAT(2)) u_d2 (
    .CLK(CLK), .RST(RST), .ENraf(enr2), .Enwrk(Enwrk), .empty(empty2), .q(q2),
    .rdreq(rdreq2), .bc(bc2), .last(last2), .busy(busy2), .ovf(ovf2));

`ifdef FIFO_READER_BCD_EN
  localparam int         N_A = 99, N_C = 42;
  localparam logic [7:0] BC_A = 8'h99, BC_B = 8'h00, BC_C = 8'h42;
`else
  localparam int         N_A = 255, N_C = 1;
  localparam logic [7:0] BC_A = 8'hFF, BC_B = 8'h00, BC_C = 8'h01;
`endif

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push1(input logic [7:0] b);
    mem1[wr1] = b;
    wr1++;
  endtask

  task automatic push2(input logic [7:0] b);
    mem2[wr2] = b;
    wr2++;
  endtask

  // Run until FIFO 1 is drained and reader 1 is back in IDLE.
  task automatic drain1(input string tag);
    int n = 0;
    while (!(rd1 == wr1 && !busy1 && !rdreq1) && n < 1200) begin
      tick();
      n++;
    end
    chk(tag, 32'(n < 1200), 32'd1);
  endtask

  task automatic wait_rd2(input string tag);
    int n = 0;
    while (!rdreq2 && n < 6) begin
      tick();
      n++;
    end
    chk(tag, 32'(rdreq2), 32'd1);
  endtask

  task automatic push_window(input int n, output logic [7:0] lastb);
    lastb = 8'h00;
    for (int i = 0; i < n; i++) begin
      lastb = 8'h20 + 8'(i % 95);
      push1(lastb);
    end
  endtask

  initial begin
    int pulses, prev, gap_bad, seen;
    logic [7:0] lb;

    // Reset held with data present and enables high.
    push1(8'h41); push1(8'h05); push1(8'h7E); push1(8'h7F);
    tick(); tick();
    chk("rst_rdreq", 32'(rdreq1), 32'd0);
    chk("rst_bc",    32'(bc1),    32'd0);
    chk("rst_last",  32'(last1),  32'd0);
    chk("rst_busy",  32'(busy1),  32'd0);
    chk("rst_ovf",   32'(ovf1),   32'd0);
    chk("rst_bc2",   32'(bc2),    32'd0);
    RST = 1'b1;

    // Four bytes at RD_LAT=1: pulses every 3 cycles, two dropped.
    pulses = 0; prev = -10; gap_bad = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (i == 0) begin
        chk("first_rdreq", 32'(rdreq1), 32'd1);
        chk("first_busy",  32'(busy1),  32'd1);
      end
      if (rdreq1) begin
        if (i - prev != 3 && pulses != 0) gap_bad++;
        pulses++;
        prev = i;
      end
    end
    chk("pulse_count", 32'(pulses), 32'd4);
    chk("pulse_gap",   32'(gap_bad), 32'd0);
    chk("bc_after4",   32'(bc1),    32'd2);
    chk("last_after4", 32'(last1),  32'h7E);
    chk("busy_idle",   32'(busy1),  32'd0);

    // Empty held for 20 cycles, then released.
    hold1 = 1'b1;
    push1(8'h50);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rdreq1) seen = 1;
    end
    chk("empty_no_rdreq", 32'(seen), 32'd0);
    chk("empty_bc_hold",  32'(bc1),  32'd2);
    hold1 = 1'b0;
    seen = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (rdreq1) seen = 1;
    end
    chk("empty_release", 32'(seen), 32'd1);
    drain1("drain_50");
    chk("bc_after_50",   32'(bc1),   32'd3);
    chk("last_after_50", 32'(last1), 32'h50);

    // RD_LAT=2: drop Enwrk the cycle after rdreq; the byte still counts.
    enr1 = 1'b0;
    push2(8'h30); push2(8'h31);
    enr2 = 1'b1;
    wait_rd2("rd2_first");
    tick();
    chk("rd2_no_back2back", 32'(rdreq2), 32'd0);
    Enwrk = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rdreq2) seen = 1;
    end
    chk("enwrk_no_rdreq", 32'(seen),  32'd0);
    chk("enwrk_bc",       32'(bc2),   32'd1);
    chk("enwrk_last",     32'(last2), 32'h30);
    chk("enwrk_busy",     32'(busy2), 32'd0);
    chk("enwrk_bc1_hold", 32'(bc1),   32'd3);

    // Reset asserted while reader 2 is in WAIT.
    Enwrk = 1'b1;
    wait_rd2("rd2_second");
    tick();
    chk("wait_busy", 32'(busy2), 32'd1);
    RST = 1'b0;
    #1;
    chk("midrst_rdreq", 32'(rdreq2), 32'd0);
    chk("midrst_busy",  32'(busy2),  32'd0);
    chk("midrst_bc",    32'(bc2),    32'd0);
    tick();
    RST = 1'b1;
    enr2 = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("post_rst_bc2", 32'(bc2), 32'd0);
    chk("post_rst_bc1", 32'(bc1), 32'd0);

    // Roll-over on reader 1.
    enr1 = 1'b1;
    push_window(N_A, lb);
    drain1("drain_a");
    chk("full_bc",   32'(bc1),   32'(BC_A));
    chk("full_ovf",  32'(ovf1),  32'd0);
    chk("full_last", 32'(last1), 32'(lb));
    push_window(1, lb);
    drain1("drain_b");
    chk("wrap_bc",  32'(bc1),  32'(BC_B));
    chk("wrap_ovf", 32'(ovf1), 32'd1);
    push_window(N_C, lb);
    drain1("drain_c");
    chk("after_wrap_bc",  32'(bc1),  32'(BC_C));
    chk("ovf_sticky",     32'(ovf1), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
